// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int unsigned DEF_DW    = 32;
    localparam int unsigned DEF_DEPTH = 32;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Bulk-clear sequencer: walks every entry once, then pulses done for one cycle.
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_req_i,
    output logic          clr_busy_o,
    output logic          clr_done_o,
    output logic          clr_we_c,
    output logic [AW-1:0] clr_addr_c
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state, state_n;
    logic [AW-1:0] cnt, cnt_n;

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_busy_o <= 1'b0;
            clr_done_o <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            clr_busy_o <= (state_n == CLEAR);
            clr_done_o <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (clr_req_i) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST) state_n = DONE;
                else             cnt_n   = cnt + AW'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign clr_we_c   = (state == CLEAR);
    assign clr_addr_c = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, N combinational read
// ports with optional zero register and write-to-read bypass, bulk clear.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int unsigned DW       = DEF_DW,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned ZERO_REG = 1,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we0_i,
    input  logic [AW-1:0]        waddr0_i,
    input  logic [DW-1:0]        wdata0_i,
    input  logic                 we1_i,
    input  logic [AW-1:0]        waddr1_i,
    input  logic [DW-1:0]        wdata1_i,
    input  logic [NUM_RD*AW-1:0] raddr_i,
    output logic [NUM_RD*DW-1:0] rdata_o,
    input  logic                 clr_req_i,
    output logic                 clr_busy_o,
    output logic                 clr_done_o
);

    logic [DW-1:0] mem [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wv0, wv1;

    // An address holds real storage: in range and not the hard-wired zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    reg_file_clr_fsm #(.DEPTH(DEPTH)) u_clr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_req_i  (clr_req_i),
        .clr_busy_o (clr_busy_o),
        .clr_done_o (clr_done_o),
        .clr_we_c   (clr_we),
        .clr_addr_c (clr_addr)
    );

    assign wv0 = we0_i && addr_ok(waddr0_i) && !clr_we;
    assign wv1 = we1_i && addr_ok(waddr1_i) && !clr_we;

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem <= '{default: '0};
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wv0) mem[waddr0_i] <= wdata0_i;
            if (wv1) mem[waddr1_i] <= wdata1_i;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        logic [DW-1:0] word;
        rdata_o = '0;
        ra      = '0;
        word    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra   = raddr_i[k*AW +: AW];
            word = '0;
            if (addr_ok(ra)) begin
                word = mem[ra];
                if (BYPASS != 0) begin
                    if (wv1 && (waddr1_i == ra))      word = wdata1_i;
                    else if (wv0 && (waddr0_i == ra)) word = wdata0_i;
                end
            end
            rdata_o[k*DW +: DW] = word;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two configurations driven in parallel against an array model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we0, we1, clr_req;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [9:0]  raddr;
    logic [63:0] rd_a;
    logic [31:0] rd_b;
    logic        busy_a, done_a, busy_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .we0_i(we0), .waddr0_i(wa0), .wdata0_i(wd0),
        .we1_i(we1), .waddr1_i(wa1), .wdata1_i(wd1),
        .raddr_i(raddr), .rdata_o(rd_a),
        .clr_req_i(clr_req), .clr_busy_o(busy_a), .clr_done_o(done_a)
    );

    reg_file_mp #(.DW(32), .DEPTH(24), .NUM_RD(1), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .we0_i(we0), .waddr0_i(wa0), .wdata0_i(wd0),
        .we1_i(we1), .waddr1_i(wa1), .wdata1_i(wd1),
        .raddr_i(raddr[4:0]), .rdata_o(rd_b),
        .clr_req_i(clr_req), .clr_busy_o(busy_b), .clr_done_o(done_b)
    );

    // Reference model: index 0 = dut_a, index 1 = dut_b.
    logic [31:0] mmem [2][32];
    int          left [2];
    bit          mdone[2];
    int          mdepth[2] = '{32, 24};
    bit          mzr  [2] = '{1'b1, 1'b0};
    bit          mbyp [2] = '{1'b1, 1'b0};

    function automatic bit wv(int i, logic we, logic [4:0] a);
        return we && (int'(a) < mdepth[i]) && !(mzr[i] && a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
        if (int'(a) >= mdepth[i] || (mzr[i] && a == 5'd0)) return 32'd0;
        if (mbyp[i] && left[i] == 0) begin
            if (wv(i, we1, wa1) && wa1 == a) return wd1;
            if (wv(i, we0, wa0) && wa0 == a) return wd0;
        end
        return mmem[i][a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 32; j++) mmem[i][j] = 32'd0;
                left[i]  = 0;
                mdone[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (left[i] > 0) begin
                    mmem[i][mdepth[i] - left[i]] = 32'd0;
                    left[i]  = left[i] - 1;
                    mdone[i] = (left[i] == 0);
                end else begin
                    if (wv(i, we0, wa0)) mmem[i][wa0] = wd0;
                    if (wv(i, we1, wa1)) mmem[i][wa1] = wd1;
                    if (mdone[i])     mdone[i] = 1'b0;
                    else if (clr_req) left[i]  = mdepth[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_rd0",  rd_a[31:0],  exp_rd(0, raddr[4:0]));
            chk("a_rd1",  rd_a[63:32], exp_rd(0, raddr[9:5]));
            chk("b_rd0",  rd_b,        exp_rd(1, raddr[4:0]));
            chk("a_busy", 32'(busy_a), 32'(left[0] > 0));
            chk("a_done", 32'(done_a), 32'(mdone[0]));
            chk("b_busy", 32'(busy_b), 32'(left[1] > 0));
            chk("b_done", 32'(done_b), 32'(mdone[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ba, da, bb, db;
        idle_in();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; raddr = '0;
        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rd",   rd_a[31:0],  32'd0);
        cyc(); cyc();
        rst = 1'b0;

        // Basic write then read on both ports
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
        cyc(); idle_in(); #1;
        chk("t1_a0", rd_a[31:0],  32'hDEADBEEF);
        chk("t1_a1", rd_a[63:32], 32'hDEADBEEF);
        chk("t1_b",  rd_b,        32'hDEADBEEF);
        raddr = {5'd6, 5'd4}; #1;
        chk("t1_other", rd_a[31:0] | rd_a[63:32] | rd_b, 32'd0);

        // Dual-port collision and independent writes
        cyc();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        cyc();
        wa0 = 5'd3; wd0 = 32'h03; wa1 = 5'd4; wd1 = 32'h04;
        cyc(); idle_in();
        raddr = {5'd7, 5'd3}; #1;
        chk("t2_coll", rd_a[63:32], 32'h22);
        chk("t2_p0",   rd_a[31:0],  32'h03);
        raddr = {5'd7, 5'd4}; #1;
        chk("t2_p1",   rd_a[31:0],  32'h04);
        chk("t2_b",    rd_b,        32'h04);

        // Zero register and bypass
        cyc();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; raddr = 10'd0; #1;
        chk("t3_zero_byp", rd_a[31:0], 32'd0);
        cyc(); idle_in(); #1;
        chk("t3_zero_a", rd_a[31:0], 32'd0);
        chk("t3_zero_b", rd_b,       32'hFFFFFFFF);
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h33;
        cyc(); idle_in();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5; raddr = {5'd9, 5'd9}; #1;
        chk("t3_byp_a0", rd_a[31:0],  32'hA5);
        chk("t3_byp_a1", rd_a[63:32], 32'hA5);
        chk("t3_nobyp_b", rd_b,       32'h33);
        cyc(); idle_in(); #1;
        chk("t3_after_b", rd_b, 32'hA5);

        // Address beyond the shallow instance's depth
        we0 = 1'b1; wa0 = 5'd30; wd0 = 32'h77; raddr = {5'd30, 5'd30};
        cyc(); idle_in(); #1;
        chk("t6_b_oob", rd_b,       32'd0);
        chk("t6_a_30",  rd_a[31:0], 32'h77);

        // Fill, then bulk clear with writes attempted while busy
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i);
            cyc();
        end
        idle_in();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        ba = 0; da = 0; bb = 0; db = 0;
        for (int n = 0; n < 40; n++) begin
            ba += int'(busy_a); da += int'(done_a);
            bb += int'(busy_b); db += int'(done_b);
            we0 = busy_a & busy_b; wa0 = 5'($urandom_range(1, 31)); wd0 = $urandom | 32'd1;
            cyc();
        end
        idle_in();
        chk("t4_busy_a", 32'(ba), 32'd32);
        chk("t4_done_a", 32'(da), 32'd1);
        chk("t4_busy_b", 32'(bb), 32'd24);
        chk("t4_done_b", 32'(db), 32'd1);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)}; #1;
            chk("t4_zero_a", rd_a[31:0], 32'd0);
            chk("t4_zero_b", rd_b,       32'd0);
        end

        // Reset in the middle of a clear
        cyc();
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h55;
        cyc(); idle_in();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (10) cyc();
        raddr = {5'd20, 5'd20}; #1;
        chk("t5_pre", rd_a[31:0], 32'h55);
        rst = 1'b1; #1;
        chk("t5_busy",  32'(busy_a), 32'd0);
        chk("t5_rd_a",  rd_a[31:0],  32'd0);
        chk("t5_rd_b",  rd_b,        32'd0);
        cyc(); cyc();
        rst = 1'b0;
        da = 0;
        for (int n = 0; n < 40; n++) begin
            da += int'(done_a) + int'(done_b) + int'(busy_a);
            cyc();
        end
        chk("t5_no_done", 32'(da), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom); wd1 = $urandom;
            if ($urandom_range(0, 3) == 0) wa1 = wa0;
            raddr   = 10'($urandom);
            clr_req = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            cyc();
        end
        idle_in();
        cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, the successor to the 2R/1W 32x32 register file in the single-cycle and pipelined CPU datapath.
- Configurable word width, depth and number of read ports.
- Two write ports with a fixed priority rule.
- Optional hard-wired zero register and optional same-cycle write-to-read bypass.
- Sequential bulk-clear engine that scrubs the array one entry per cycle behind a busy/done handshake.

Parameters:
DW, 32, data word width in bits
DEPTH, 32, number of registers (2..256, need not be a power of 2)
AW, $clog2(DEPTH), address width (derived; not overridden)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a read of an address being written this cycle returns the write data

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  asynchronous active-high reset
we0_i  in  1  write enable, port 0
waddr0_i  in  AW  write address, port 0
wdata0_i  in  DW  write data, port 0
we1_i  in  1  write enable, port 1 (higher priority)
waddr1_i  in  AW  write address, port 1
wdata1_i  in  DW  write data, port 1
raddr_i  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW]
rdata_o  out  NUM_RD*DW  packed read data; port k uses bits [k*DW +: DW]
clr_req_i  in  1  bulk-clear request (level, sampled in IDLE)
clr_busy_o  out  1  clear engine active
clr_done_o  out  1  one-cycle pulse when the clear completes

Behaviour:
Reset:
- rst_i high clears all entries to 0, FSM to IDLE, clear counter to 0, clr_busy_o=0, clr_done_o=0.
- The clear is immediate and independent of clk_i.
- Reset mid-clear aborts the clear; no clr_done_o pulse is produced.

Reads:
- Combinational, zero latency: rdata_o[k] = array[raddr_k].
- Address >= DEPTH reads 0.
- ZERO_REG=1: address 0 always reads 0.

Bypass (BYPASS=1, FSM not in CLEAR):
- If weN_i and waddrN_i == raddr_k (valid, non-zero when ZERO_REG=1), rdata_o[k] = wdataN_i.
- If both ports match, port 1 data is returned.
- BYPASS=0: reads return pre-edge array contents.

Writes (rising edge):
- Written only when weN_i=1, address < DEPTH, and the address is not 0 when ZERO_REG=1.
- Both ports writing the same address in one cycle: port 1 value is stored and port 0 is dropped.
- Different addresses: both are stored.
- Write ports are ignored while clr_busy_o=1.

Clear FSM (states IDLE, CLEAR, DONE):
- IDLE: clr_req_i=1 moves to CLEAR, cnt<=0. clr_busy_o is asserted from the next cycle.
- CLEAR: each edge writes 0 to array[cnt] and increments cnt. When cnt==DEPTH-1, the entry is zeroed and the FSM moves to DONE. Total of exactly DEPTH cycles in CLEAR.
- DONE: clr_done_o=1 and clr_busy_o=0 for exactly one cycle, then IDLE unconditionally. A clr_req_i still high in DONE is ignored; it is re-sampled in IDLE.
- clr_req_i during CLEAR or DONE is ignored.
- clr_busy_o=1 exactly in CLEAR.
- Reads during CLEAR return current array contents, including already-zeroed entries; bypass is disabled in CLEAR.
- Writes presented on the same edge the FSM leaves IDLE for CLEAR are accepted (busy not yet high).

Decomposition:
- Shared package reg_file_pkg: clear-FSM state enum (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2) and the default DW/DEPTH constants used by the CPU top.
- One sub-module reg_file_clr_fsm holds the state, counter and handshake outputs, and produces clr_we / clr_addr for the array.
- Array, write arbitration and read/bypass muxes stay in reg_file_mp.

Test Plan:
1. Reset, then write 0xDEADBEEF to reg 5 via port 0, read it on both ports next cycle -> rdata both 0xDEADBEEF; all other addresses read 0.
2. Same edge: port 0 writes 0x11 and port 1 writes 0x22, both to reg 7 -> reg 7 == 0x22. Port 0 to reg 3 and port 1 to reg 4 -> both stored.
3. ZERO_REG=1: write 0xFFFFFFFF to reg 0 -> reads 0. BYPASS=1: write 0xA5 to reg 9 while raddr=9 -> same-cycle rdata 0xA5. BYPASS=0 -> old value.
4. Fill regs 1..31 with their index, pulse clr_req_i -> clr_busy_o high for 32 cycles, clr_done_o high for 1 cycle after, all regs 0. Writes issued while busy have no effect.
5. Start clear, assert rst_i at cycle 10 of CLEAR -> outputs 0 immediately, FSM IDLE, no clr_done_o pulse.
6. DEPTH=24 (AW=5): write to address 30 -> ignored; read of address 30 -> 0; clear completes in 24 cycles.
